// File: rtl/uart_rx.sv
// uart_rx: asynchronous serial receiver with a small output FIFO.
// Mid-bit sampling with a down-counting bit timer, LSB-first payload,
// frame-error / break / overrun pulses.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | line idle, watching for a synchronized 1->0 transition
// START     | waiting half a bit, then confirming the start bit is low
// DATA      | sampling PAYLOAD_BITS data bits at their midpoints
// STOP      | sampling the stop bit; good word is pushed to the FIFO
// WAIT_IDLE | bad stop seen; ignore the line until it returns high
module uart_rx #(
  parameter int CLK_HZ       = 25200000,
  parameter int BIT_RATE     = 115200,
  parameter int PAYLOAD_BITS = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          uart_rxd,
  output logic [PAYLOAD_BITS-1:0]       uart_rx_data,
  output logic                          uart_rx_valid,
  input  logic                          uart_rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   uart_rx_count,
  output logic                          uart_rx_frame_err,
  output logic                          uart_rx_break,
  output logic                          uart_rx_overrun
);

  localparam int CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
  localparam int HALF_BIT       = CYCLES_PER_BIT / 2;
  localparam int CNT_W          = $clog2(CYCLES_PER_BIT);
  localparam int IDX_W          = $clog2(PAYLOAD_BITS + 1);
  localparam int PTR_W          = $clog2(FIFO_DEPTH);
  localparam int CNTF_W         = PTR_W + 1;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

  state_t                  state;
  logic                    rxd_s1, rxd_s2, rxd_prev;
  logic [CNT_W-1:0]        bit_cnt;
  logic [IDX_W-1:0]        bit_idx;
  logic [PAYLOAD_BITS-1:0] shift;

  logic [PAYLOAD_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic [CNTF_W-1:0]       count_next;
  logic                    push, pop, full, wr_en;

  // Two-flop synchronizer plus a delayed copy for falling-edge detection.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rxd_s1   <= 1'b1;
      rxd_s2   <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_s1   <= uart_rxd;
      rxd_s2   <= rxd_s1;
      rxd_prev <= rxd_s2;
    end
  end

  // Frame state machine; bit timer counts down to zero, sampling at terminal count.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state             <= IDLE;
      bit_cnt           <= '0;
      bit_idx           <= '0;
      shift             <= '0;
      uart_rx_frame_err <= 1'b0;
      uart_rx_break     <= 1'b0;
    end else begin
      uart_rx_frame_err <= 1'b0;
      uart_rx_break     <= 1'b0;
      case (state)
        IDLE: begin
          if (rxd_prev && !rxd_s2) begin
            state   <= START;
            bit_cnt <= CNT_W'(HALF_BIT - 1);
          end
        end
        START: begin
          if (bit_cnt == '0) begin
            if (!rxd_s2) begin
              state   <= DATA;
              bit_cnt <= CNT_W'(CYCLES_PER_BIT - 1);
              bit_idx <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            bit_cnt <= bit_cnt - 1'b1;
          end
        end
        DATA: begin
          if (bit_cnt == '0) begin
            shift   <= {rxd_s2, shift[PAYLOAD_BITS-1:1]};
            bit_cnt <= CNT_W'(CYCLES_PER_BIT - 1);
            if (bit_idx == IDX_W'(PAYLOAD_BITS - 1)) state <= STOP;
            else bit_idx <= bit_idx + 1'b1;
          end else begin
            bit_cnt <= bit_cnt - 1'b1;
          end
        end
        STOP: begin
          if (bit_cnt == '0) begin
            if (rxd_s2) begin
              state <= IDLE;
            end else begin
              uart_rx_frame_err <= 1'b1;
              uart_rx_break     <= (shift == '0);
              state             <= WAIT_IDLE;
            end
          end else begin
            bit_cnt <= bit_cnt - 1'b1;
          end
        end
        WAIT_IDLE: begin
          if (rxd_s2) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A good stop bit pushes the assembled word in the sampling cycle itself.
  assign push  = (state == STOP) && (bit_cnt == '0) && rxd_s2;
  assign pop   = uart_rx_valid && uart_rx_ready;
  assign full  = (uart_rx_count == CNTF_W'(FIFO_DEPTH));
  assign wr_en = push && (!full || pop);
  assign uart_rx_data = mem[rd_ptr];

  // Next occupancy from the accepted push/pop pair.
  always_comb begin
    count_next = uart_rx_count;
    case ({wr_en, pop})
      2'b10:   count_next = uart_rx_count + CNTF_W'(1);
      2'b01:   count_next = uart_rx_count - CNTF_W'(1);
      default: count_next = uart_rx_count;
    endcase
  end

  // FIFO storage, pointers, occupancy and overrun pulse.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      uart_rx_count   <= '0;
      uart_rx_valid   <= 1'b0;
      uart_rx_overrun <= 1'b0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= shift;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      uart_rx_count   <= count_next;
      uart_rx_valid   <= (count_next != '0);
      uart_rx_overrun <= push && full && !pop;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed vector table plus hand-written corner sequences.
module tb_uart_rx;

  localparam int CPB = 218;
  localparam int LAT = 2074;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       uart_rxd = 1'b1;
  logic [7:0] uart_rx_data;
  logic       uart_rx_valid;
  logic       uart_rx_ready = 1'b1;
  logic [2:0] uart_rx_count;
  logic       uart_rx_frame_err, uart_rx_break, uart_rx_overrun;

  uart_rx dut (
    .clk(clk), .resetn(resetn), .uart_rxd(uart_rxd),
    .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid),
    .uart_rx_ready(uart_rx_ready), .uart_rx_count(uart_rx_count),
    .uart_rx_frame_err(uart_rx_frame_err), .uart_rx_break(uart_rx_break),
    .uart_rx_overrun(uart_rx_overrun)
  );

  always #20 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_ferr = 0, n_brk = 0, n_ovr = 0;
  int last_rise = -1;
  int t_start = 0;
  logic prev_valid = 1'b0;
  logic [7:0] rx_q[$];
  int pop_cyc[$];

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_pop;
    int         exp_ferr;
    int         exp_brk;
  } vec_t;

  vec_t vecs[7];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (resetn) begin
      if (uart_rx_valid && uart_rx_ready) begin
        rx_q.push_back(uart_rx_data);
        pop_cyc.push_back(cyc);
      end
      if (uart_rx_valid && !prev_valid) last_rise = cyc;
      if (uart_rx_frame_err) n_ferr++;
      if (uart_rx_break) n_brk++;
      if (uart_rx_overrun) n_ovr++;
      prev_valid = uart_rx_valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic hold(input logic v, input int n);
    uart_rxd = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    t_start = cyc;
    hold(1'b0, CPB);
    for (int i = 0; i < 8; i++) hold(d[i], CPB);
    hold(stop, CPB);
    hold(1'b1, 2 * CPB);
  endtask

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1, 0, 0};
    vecs[1] = '{8'h3C, 1'b0, 0, 1, 0};
    vecs[2] = '{8'h3C, 1'b1, 1, 0, 0};
    vecs[3] = '{8'h00, 1'b1, 1, 0, 0};
    vecs[4] = '{8'hFF, 1'b1, 1, 0, 0};
    vecs[5] = '{8'h00, 1'b0, 0, 1, 1};
    vecs[6] = '{8'h80, 1'b0, 0, 1, 0};

    // reset state
    #5;
    chk("rst_valid", uart_rx_valid, 0);
    chk("rst_count", uart_rx_count, 0);
    chk("rst_data", uart_rx_data, 0);
    chk("rst_ferr", uart_rx_frame_err, 0);
    chk("rst_brk", uart_rx_break, 0);
    chk("rst_ovr", uart_rx_overrun, 0);
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    hold(1'b1, 20);

    // vector table
    for (int k = 0; k < 7; k++) begin
      int p0, f0, b0;
      p0 = rx_q.size(); f0 = n_ferr; b0 = n_brk;
      send_frame(vecs[k].data, vecs[k].stop);
      chk($sformatf("v%0d_pops", k), rx_q.size() - p0, vecs[k].exp_pop);
      chk($sformatf("v%0d_ferr", k), n_ferr - f0, vecs[k].exp_ferr);
      chk($sformatf("v%0d_brk", k), n_brk - b0, vecs[k].exp_brk);
      chk($sformatf("v%0d_count", k), uart_rx_count, 0);
      if (vecs[k].exp_pop == 1 && rx_q.size() > p0) begin
        chk($sformatf("v%0d_data", k), rx_q[rx_q.size()-1], vecs[k].data);
        chk($sformatf("v%0d_latency", k), last_rise - t_start, LAT);
        chk($sformatf("v%0d_valid_1cyc", k), pop_cyc[pop_cyc.size()-1] - last_rise, 0);
      end
    end

    // short low glitch on idle line
    begin
      int p0, f0, b0;
      p0 = rx_q.size(); f0 = n_ferr; b0 = n_brk;
      hold(1'b0, 50);
      hold(1'b1, 2 * CPB);
      chk("glitch_pops", rx_q.size() - p0, 0);
      chk("glitch_ferr", n_ferr - f0, 0);
      chk("glitch_brk", n_brk - b0, 0);
      chk("glitch_valid", uart_rx_valid, 0);
      p0 = rx_q.size();
      send_frame(8'h69, 1'b1);
      chk("after_glitch_pops", rx_q.size() - p0, 1);
      if (rx_q.size() > p0) chk("after_glitch_data", rx_q[rx_q.size()-1], 8'h69);
    end

    // line held low for three frame times
    begin
      int p0, f0, b0;
      p0 = rx_q.size(); f0 = n_ferr; b0 = n_brk;
      hold(1'b0, 30 * CPB);
      hold(1'b1, 2 * CPB);
      chk("break_pops", rx_q.size() - p0, 0);
      chk("break_ferr", n_ferr - f0, 1);
      chk("break_brk", n_brk - b0, 1);
      send_frame(8'h55, 1'b1);
      chk("post_break_pops", rx_q.size() - p0, 1);
      if (rx_q.size() > p0) chk("post_break_data", rx_q[rx_q.size()-1], 8'h55);
    end

    // overrun with consumer stalled
    begin
      int p0, o0;
      p0 = rx_q.size(); o0 = n_ovr;
      uart_rx_ready = 1'b0;
      for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1);
      chk("ovr_count4", uart_rx_count, 4);
      chk("ovr_none_yet", n_ovr - o0, 0);
      send_frame(8'h05, 1'b1);
      chk("ovr_count_full", uart_rx_count, 4);
      chk("ovr_pulse", n_ovr - o0, 1);
      chk("ovr_no_pops", rx_q.size() - p0, 0);
      uart_rx_ready = 1'b1;
      hold(1'b1, 10);
      chk("drain_pops", rx_q.size() - p0, 4);
      if (rx_q.size() == p0 + 4) begin
        for (int i = 0; i < 4; i++) begin
          chk($sformatf("drain_data%0d", i), rx_q[p0+i], i + 1);
          if (i > 0) chk($sformatf("drain_gap%0d", i), pop_cyc[p0+i] - pop_cyc[p0+i-1], 1);
        end
      end
      chk("drain_count", uart_rx_count, 0);
      chk("drain_valid", uart_rx_valid, 0);
    end

    // reset during bit 4 of 0xF0
    begin
      int p0, f0;
      hold(1'b0, CPB);
      for (int i = 0; i < 4; i++) hold(1'b0, CPB);
      hold(1'b1, CPB / 2);
      resetn = 1'b0;
      #2;
      chk("midrst_valid", uart_rx_valid, 0);
      chk("midrst_count", uart_rx_count, 0);
      chk("midrst_data", uart_rx_data, 0);
      hold(1'b1, 5);
      resetn = 1'b1;
      p0 = rx_q.size(); f0 = n_ferr;
      hold(1'b1, 5 * CPB);
      chk("aborted_pops", rx_q.size() - p0, 0);
      chk("aborted_ferr", n_ferr - f0, 0);
      send_frame(8'h0F, 1'b1);
      chk("post_rst_pops", rx_q.size() - p0, 1);
      if (rx_q.size() > p0) chk("post_rst_data", rx_q[rx_q.size()-1], 8'h0F);
      chk("post_rst_ferr", n_ferr - f0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_HZ, default 25200000: clk frequency in Hz.
REQ-002 Parameter BIT_RATE, default 115200: serial bit rate.
REQ-003 Parameter PAYLOAD_BITS, default 8: data bits per frame.
REQ-004 Parameter FIFO_DEPTH, default 4: output buffer entries; power of 2, 2..16.
REQ-005 clk  input  1  single clock; all logic on its rising edge.
REQ-006 resetn  input  1  asynchronous, active-low reset.
REQ-007 uart_rxd  input  1  asynchronous serial line from the SAMD21; idle high.
REQ-008 uart_rx_data  output  PAYLOAD_BITS  data word at the FIFO head.
REQ-009 uart_rx_valid  output  1  FIFO is not empty; uart_rx_data is valid.
REQ-010 uart_rx_ready  input  1  consumer accepts the head word when it is high together with valid.
REQ-011 uart_rx_count  output  $clog2(FIFO_DEPTH)+1  number of words currently held.
REQ-012 uart_rx_frame_err  output  1  one-cycle pulse when a frame is received with a bad stop bit.
REQ-013 uart_rx_break  output  1  one-cycle pulse when a break condition is detected.
REQ-014 uart_rx_overrun  output  1  one-cycle pulse when a good word is dropped because the FIFO is full.

Function
REQ-015 CYCLES_PER_BIT = CLK_HZ/BIT_RATE using integer truncation (218 at the defaults); HALF_BIT = CYCLES_PER_BIT/2 (109).
REQ-016 uart_rxd passes through a 2-flop synchronizer, both flops reset to 1; all later logic uses only the synchronized value.
REQ-017 State machine states: IDLE, START, DATA, STOP, WAIT_IDLE.
REQ-018 IDLE: a synchronized falling edge (1 then 0) moves to START and clears the bit-period counter.
REQ-019 START: after HALF_BIT cycles, sample the line.
- Line = 0: go to DATA.
- Line = 1: treat as a glitch, return to IDLE, produce no output.
REQ-020 DATA: sample every CYCLES_PER_BIT cycles after the start midpoint.
- Bits are shifted in LSB first.
- After PAYLOAD_BITS samples, go to STOP.
REQ-021 STOP: sample CYCLES_PER_BIT cycles after the last data sample.
- Stop = 1: push the word into the FIFO on that cycle; return to IDLE.
- Stop = 0: pulse uart_rx_frame_err and discard the word.
REQ-022 Break: if stop = 0 and all data bits = 0, pulse uart_rx_break in the same cycle as uart_rx_frame_err.
REQ-023 After any stop = 0, go to WAIT_IDLE; stay there until the line reads 1; no new start is detected during WAIT_IDLE.
REQ-024 Latency: uart_rx_valid and uart_rx_data are updated on the clock edge following the push cycle (registered FIFO outputs).
REQ-025 Pop: occurs on any cycle with uart_rx_valid=1 and uart_rx_ready=1; the next word appears the following cycle.
REQ-026 Push when full with no simultaneous pop: drop the word, pulse uart_rx_overrun, leave FIFO contents unchanged.
REQ-027 Push and pop in the same cycle when full: both are accepted; count is unchanged; no overrun.
REQ-028 Push and pop in the same cycle when empty: not possible because valid=0; the push takes effect and count becomes 1.
REQ-029 FIFO read/write pointers wrap modulo FIFO_DEPTH; count stays in the range 0..FIFO_DEPTH.
REQ-030 Ready while empty: uart_rx_ready=1 with valid=0 has no effect.
REQ-031 Error pulses are high for exactly one cycle and are never sticky.

Reset
REQ-032 While resetn=0 (asynchronous):
- state = IDLE, counters = 0, synchronizer = 1, FIFO emptied.
- uart_rx_valid=0, uart_rx_data=0, uart_rx_count=0.
- uart_rx_frame_err=0, uart_rx_break=0, uart_rx_overrun=0.
REQ-033 Reset asserted mid-frame abandons the partial word; after release, reception starts only on a fresh falling edge.

Verification
REQ-034 Defaults, ready=1, send 0xA5 with valid stop -> valid=1 with data=0xA5 for one cycle, at 2 sync cycles + 9.5 bit periods + 1 after the start edge; count returns to 0.
REQ-035 Low glitch of 50 cycles on an idle line -> no valid, no error pulses, state back in IDLE.
REQ-036 Frame 0x3C with stop bit forced to 0 -> single frame_err pulse, no break, count stays 0; next 0x3C with a good stop -> received.
REQ-037 Line held low for 3 frame times, then released -> exactly one frame_err and one break pulse; no push; normal 0x55 received afterwards.
REQ-038 ready=0, send 0x01..0x05 -> count reaches 4, one overrun pulse on the fifth word; then ready=1 -> reads 0x01,0x02,0x03,0x04 on consecutive cycles.
REQ-039 resetn pulsed low during bit 4 of 0xF0, then send 0x0F -> no output for the aborted frame; 0x0F received correctly.
